tone_decoder: RTL and testbench
===============================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 The block SHALL have one parameter per line: SYNC_STAGES, default 2, number of flops in the sound_in synchronizer.
REQ-002 The block SHALL have one parameter per line: CNT_W, default 8, width of the edge counter, which saturates at 2^CNT_W-1.
REQ-003 Port clk, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1, reset; it SHALL be asynchronous and active-high.
REQ-005 Port ticks_per_milli, input, 16, clk cycles per millisecond; a value of 0 SHALL be treated as 1.
REQ-006 Port sound_in, input, 1, asynchronous square-wave tone input.
REQ-007 Port note, output, 4, semitone index 0..11 (C4..B4); 4'hF SHALL mean no note.
REQ-008 Port note_valid, output, 1, one-cycle pulse each time note is updated.
REQ-009 Port silence, output, 1, high while the last gate count was below the C4 threshold.
REQ-010 Port led, output, 8, seven-segment drive: bits [6:0] are segments a..g, active-high; bit 7 is the sharp indicator.

Function
REQ-011 sound_in SHALL pass through a SYNC_STAGES synchronizer; a rising edge SHALL be detected as a 0->1 transition of the synchronized signal.
REQ-012 The ms prescaler SHALL reload with ticks_per_milli-1 and count down to 0.
- A change to ticks_per_milli takes effect at the next reload.
REQ-013 The state machine SHALL have three states:
- IDLE: entered from reset; moves to GATE on the next cycle.
- GATE: lasts GATE_MS=250 ms; moves to EVAL when the final ms expires.
- EVAL: one cycle; moves to GATE.
REQ-014 In GATE, the edge counter SHALL increment on each detected rising edge and saturate at 2^CNT_W-1.
- The counter clears on entry to GATE.
- An edge in the EVAL cycle SHALL be dropped.
REQ-015 In EVAL, the count c SHALL be classified against the package threshold table LO[0..11] = 63,67,71,75,80,84,89,95,101,107,113,120 and HI = 127:
- Note i when LO[i] <= c < LO[i+1], with LO[12] taken as HI+1.
- c < 63: no note (4'hF) with silence=1.
- c > 127: no note with silence=0.
REQ-016 The outputs SHALL update in the cycle after EVAL, with note_valid pulsed in that same cycle.
REQ-017 led SHALL be decoded combinationally from the registered note:
- Letters C,C#,D,D#,E,F,F#,G,G#,A,A#,B use the package segment codes; sharps set led[7].
- No note gives 8'h00.
- Example: A = 8'h77, C# = 8'hB9.

Reset
REQ-018 While rst is high, the outputs SHALL be note=4'hF, note_valid=0, silence=1 and led=8'h00.
REQ-019 While rst is high, the FSM SHALL be in IDLE and the counters and synchronizer SHALL be 0.
REQ-020 Asserting rst mid-gate SHALL discard the partial count; the first gate after release SHALL start from zero.

Configuration
REQ-021 With STABLE_FILTER_EN defined, a new classification SHALL update the outputs only when it equals the previous gate's classification.
- A first or differing result is stored as the candidate only: no note_valid pulse and no output change.
- After reset the candidate is 4'hE, an invalid code, so the first gate never updates.
REQ-022 Without STABLE_FILTER_EN, every EVAL SHALL update the outputs and pulse note_valid.

Structure
REQ-023 Package tone_decoder_pkg SHALL hold:
- GATE_MS;
- the LO/HI threshold table;
- NOTE_NONE=4'hF;
- the 12-entry segment-code table;
- the FSM state typedef.
REQ-024 The synchronizer and edge detector SHALL be the sub-module tone_sync_edge; the prescaler, FSM, counter and classifier SHALL stay in tone_decoder.

Verification
REQ-025 A 440 Hz sound_in with ticks_per_milli=100, filter off SHALL produce count 110, note=9, led=8'h77 and a single note_valid pulse at the end of the gate.
REQ-026 A 440 Hz input with STABLE_FILTER_EN SHALL give no pulse after gate 1 and note=9 with a pulse after gate 2; switching to 262 Hz (count 65) SHALL give note=0 only after two further gates.
REQ-027 Boundary counts SHALL classify as follows: 63 edges -> note 0; 62 edges -> note 4'hF with silence=1; 127 -> note 11; 128 -> 4'hF with silence=0.
REQ-028 A 2 kHz input (500 edges) SHALL saturate the counter at 255 and give note 4'hF with silence=0, with no counter wrap.
REQ-029 Asserting rst at 120 ms into a gate with a 440 Hz input SHALL force the reset values and give a full 250 ms gate before the next note_valid.
REQ-030 With ticks_per_milli=0 and clk ticking, EVAL SHALL occur every 250 cycles.

Source files
------------

// File: rtl/tone_decoder_pkg.sv
// Shared constants, threshold/segment tables and helpers for the tone decoder.
package tone_decoder_pkg;

  localparam int unsigned GATE_MS   = 250;
  localparam int          NUM_NOTES = 12;
  localparam logic [3:0]  NOTE_NONE = 4'hF;
  localparam logic [3:0]  NOTE_INIT = 4'hE;

  // Lower edge-count bound for each semitone C4..B4; HI is the top of B4.
  localparam int LO_TABLE [NUM_NOTES] = '{63, 67, 71, 75, 80, 84, 89, 95, 101, 107, 113, 120};
  localparam int HI = 127;

  // Segments a..g in bits [6:0]; sharps reuse the natural letter's shape.
  localparam logic [6:0] SEG_TABLE [NUM_NOTES] = '{
    7'h39, 7'h39, 7'h5E, 7'h5E, 7'h79, 7'h71, 7'h71, 7'h3D, 7'h3D, 7'h77, 7'h77, 7'h7C
  };
  localparam logic [11:0] SHARP_MASK = 12'b0101_0100_1010;

  typedef enum logic [1:0] {StIdle, StGate, StEval} state_e;

  // Returns {silence, note}.
  function automatic logic [4:0] classify(input int cnt);
    logic [3:0] n;
    n = NOTE_NONE;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (cnt >= LO_TABLE[i]) n = 4'(i);
    end
    if (cnt > HI) n = NOTE_NONE;
    return {(cnt < LO_TABLE[0]), n};
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] note);
    logic [7:0] led;
    led = 8'h00;
    if (note < 4'd12) led = {SHARP_MASK[note], SEG_TABLE[note]};
    return led;
  endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// Multi-flop synchronizer for the asynchronous tone input plus rising-edge detector.
module tone_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sound_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= sound_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tone_decoder.sv
// Gated edge-count tone decoder: counts input edges over a 250 ms gate and maps them to C4..B4.
// Optional STABLE_FILTER_EN: only publish a classification seen on two consecutive gates.
module tone_decoder
  import tone_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ticks_per_milli,
  input  logic        sound_in,
  output logic [3:0]  note,
  output logic        note_valid,
  output logic        silence,
  output logic [7:0]  led
);

  localparam logic [7:0] MS_LAST = 8'(GATE_MS - 1);

  logic             rise;
  state_e           state_q, state_d;
  logic [15:0]      presc_q, presc_d;
  logic [7:0]       ms_q, ms_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       note_q, note_d;
  logic             valid_q, valid_d;
  logic             sil_q, sil_d;
  logic [15:0]      reload;
  logic             tick;
  logic [4:0]       cls;
`ifdef STABLE_FILTER_EN
  logic [4:0]       cand_q, cand_d;
`endif

  tone_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk_i  (clk),
    .rst_i  (rst),
    .sound_i(sound_in),
    .rise_o (rise)
  );

  assign reload = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
  assign tick   = (presc_q == 16'd0);
  assign cls    = classify(int'(cnt_q));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ms_d    = ms_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    valid_d = 1'b0;
    sil_d   = sil_q;
`ifdef STABLE_FILTER_EN
    cand_d  = cand_q;
`endif

    // The ms timebase free-runs through EVAL so every gate period is exactly GATE_MS.
    if (state_q != StIdle) begin
      if (tick) begin
        presc_d = reload;
        ms_d    = (ms_q == MS_LAST) ? 8'd0 : ms_q + 8'd1;
      end else begin
        presc_d = presc_q - 16'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        presc_d = reload;
        ms_d    = 8'd0;
        cnt_d   = '0;
        state_d = StGate;
      end
      StGate: begin
        if (rise && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        if (tick && (ms_q == MS_LAST)) state_d = StEval;
      end
      StEval: begin
        cnt_d   = '0;
        state_d = StGate;
`ifdef STABLE_FILTER_EN
        cand_d = cls;
        if (cls == cand_q) begin
          note_d  = cls[3:0];
          sil_d   = cls[4];
          valid_d = 1'b1;
        end
`else
        note_d  = cls[3:0];
        sil_d   = cls[4];
        valid_d = 1'b1;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      presc_q <= 16'd0;
      ms_q    <= 8'd0;
      cnt_q   <= '0;
      note_q  <= NOTE_NONE;
      valid_q <= 1'b0;
      sil_q   <= 1'b1;
`ifdef STABLE_FILTER_EN
      cand_q  <= {1'b0, NOTE_INIT};
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      sil_q   <= sil_d;
`ifdef STABLE_FILTER_EN
      cand_q  <= cand_d;
`endif
    end
  end

  assign note       = note_q;
  assign note_valid = valid_q;
  assign silence    = sil_q;
  assign led        = seg_decode(note_q);

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench for tone_decoder: directed edge-count gates, reset abort and tpm=0 timing.
`timescale 1ns/1ps
module tb_tone_decoder;

  localparam int GATE_CYC = 4000;  // 250 ms at 16 clk/ms
`ifdef STABLE_FILTER_EN
  localparam int FILT = 2;
`else
  localparam int FILT = 1;
`endif

  typedef struct {
    logic [3:0] note;
    logic       sil;
    logic [7:0] led;
  } exp_t;

  typedef struct {
    int         n;
    logic [3:0] note;
    logic       sil;
    logic [7:0] led;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tpm = 16'd16;
  logic        sound_in = 1'b0;
  logic [3:0]  note;
  logic        note_valid;
  logic        silence;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned last_nv_cyc = 0;
  int unsigned nv_times[$];
  exp_t sb[$];

  tone_decoder #(
    .SYNC_STAGES(2),
    .CNT_W(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ticks_per_milli(tpm),
    .sound_in       (sound_in),
    .note           (note),
    .note_valid     (note_valid),
    .silence        (silence),
    .led            (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every note_valid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (note_valid === 1'b1) begin
        last_nv_cyc = cyc;
        nv_times.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_note_valid: got pulse at cycle %0d required none", cyc);
        end else begin
          e = sb.pop_front();
          check("note", 32'(note), 32'(e.note));
          check("silence", 32'(silence), 32'(e.sil));
          check("led", 32'(led), 32'(e.led));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_note"}, 32'(note), 32'hF);
    check({tag, "_note_valid"}, 32'(note_valid), 32'h0);
    check({tag, "_silence"}, 32'(silence), 32'h1);
    check({tag, "_led"}, 32'(led), 32'h00);
  endtask

  // One gate of stimulus: n rising edges with a 6-cycle period, margins at both ends.
  task automatic run_gate(input int n);
    for (int i = 0; i < GATE_CYC; i++) begin
      @(negedge clk);
      sound_in = (i >= 40) && (i < 40 + 6 * n) && (((i - 40) % 6) < 3);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] n, input logic s, input logic [7:0] l);
    exp_t e;
    e.note = n;
    e.sil  = s;
    e.led  = l;
    return e;
  endfunction

  vec_t vecs[7];
  int unsigned rel;

  initial begin
    vecs[0] = '{110, 4'd9,  1'b0, 8'h77};
    vecs[1] = '{63,  4'd0,  1'b0, 8'h39};
    vecs[2] = '{128, 4'hF,  1'b0, 8'h00};
    vecs[3] = '{62,  4'hF,  1'b1, 8'h00};
    vecs[4] = '{127, 4'd11, 1'b0, 8'h7C};
    vecs[5] = '{500, 4'hF,  1'b0, 8'h00};
    vecs[6] = '{65,  4'd0,  1'b0, 8'h39};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    foreach (vecs[v]) begin
      sb.push_back(mk(vecs[v].note, vecs[v].sil, vecs[v].led));
      repeat (FILT) run_gate(vecs[v].n);
    end

    // Abort a gate 120 ms in while edges are arriving.
    for (int i = 0; i < 120 * 16; i++) begin
      @(negedge clk);
      sound_in = (i >= 40) && (((i - 40) % 6) < 3);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("midgate_reset");
    sound_in = 1'b0;
    rst = 1'b0;
    rel = cyc;
    sb.push_back(mk(4'd0, 1'b0, 8'h39));
    repeat (FILT) run_gate(63);
    repeat (10) @(negedge clk);
    check("post_reset_latency", last_nv_cyc - rel, 32'(FILT * GATE_CYC + 2));

    // ticks_per_milli = 0 behaves as 1: one EVAL every 250 cycles.
    rst = 1'b1;
    tpm = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    nv_times.delete();
    sb.push_back(mk(4'hF, 1'b1, 8'h00));
    sb.push_back(mk(4'hF, 1'b1, 8'h00));
    for (int i = 0; i < 1200 && nv_times.size() < 2; i++) @(negedge clk);
    check("tpm0_pulse_count", 32'(nv_times.size()), 32'd2);
    if (nv_times.size() >= 2) begin
      check("tpm0_first_latency", nv_times[0] - rel, 32'(FILT * 250 + 2));
      check("tpm0_interval", nv_times[1] - nv_times[0], 32'd250);
    end
    repeat (100) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
